// File: rtl/regfile_mp.sv
// Multi-port register file with PC alias, post-reset clear sequencer and
// optional same-cycle write->read forwarding.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   ra / rd            NRD packed read address / read data ports (combinational)
//   pc_in              value returned for the top index (NREGS-1)
//   we_a/wa_a/wd_a     write port A
//   we_b/wa_b/wd_b     write port B (long-multiply high word); wins on collision
//   ready              array cleared, writes accepted
//   err_coll           one-cycle pulse: A and B wrote the same address
//   err_pcwr           one-cycle pulse: an enabled write targeted the PC index
module regfile_mp #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NREGS  = 16,
    parameter int unsigned NRD    = 2,
    parameter int unsigned BYPASS = 0,
    parameter int unsigned AW     = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NRD*AW-1:0]    ra,
    output logic [NRD*WIDTH-1:0] rd,
    input  logic [WIDTH-1:0]     pc_in,
    input  logic                 we_a,
    input  logic [AW-1:0]        wa_a,
    input  logic [WIDTH-1:0]     wd_a,
    input  logic                 we_b,
    input  logic [AW-1:0]        wa_b,
    input  logic [WIDTH-1:0]     wd_b,
    output logic                 ready,
    output logic                 err_coll,
    output logic                 err_pcwr
);

    localparam logic [AW-1:0] PC_IDX   = AW'(NREGS - 1);
    localparam logic [AW-1:0] CLR_LAST = AW'(NREGS - 2);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t              state;
    logic [AW-1:0]       clr_idx;
    // The PC index has no storage behind it.
    logic [WIDTH-1:0]    rf [NREGS-1];

    // Enabled writes that actually land in storage.
    logic wr_a_ok;
    logic wr_b_ok;
    assign wr_a_ok = we_a && (wa_a != PC_IDX);
    assign wr_b_ok = we_b && (wa_b != PC_IDX);

    // Clear sequencer, write ports and error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            clr_idx  <= '0;
            ready    <= 1'b0;
            err_coll <= 1'b0;
            err_pcwr <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    rf[clr_idx] <= '0;
                    clr_idx     <= clr_idx + AW'(1);
                    err_coll    <= 1'b0;
                    err_pcwr    <= 1'b0;
                    if (clr_idx == CLR_LAST) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    // B is written after A so it wins on a shared address.
                    if (wr_a_ok) rf[wa_a] <= wd_a;
                    if (wr_b_ok) rf[wa_b] <= wd_b;
                    err_coll <= wr_a_ok && wr_b_ok && (wa_a == wa_b);
                    err_pcwr <= (we_a && (wa_a == PC_IDX)) || (we_b && (wa_b == PC_IDX));
                end
                default: begin
                    state <= CLEAR;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Independent combinational read ports.
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;

        assign addr = ra[i*AW +: AW];

        always_comb begin
            data = '0;
            if (ready) begin
                if (addr == PC_IDX) begin
                    data = pc_in;
                end else if ((BYPASS != 0) && wr_b_ok && (wa_b == addr)) begin
                    data = wd_b;
                end else if ((BYPASS != 0) && wr_a_ok && (wa_a == addr)) begin
                    data = wd_a;
                end else begin
                    data = rf[addr];
                end
            end
        end

        assign rd[i*WIDTH +: WIDTH] = data;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (BYPASS=0 and BYPASS=1) share all inputs.
module tb_regfile_mp;

    localparam int unsigned W  = 32;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] ra0 = '0, ra1 = '0;
    logic [W-1:0]  pc_in = '0;
    logic          we_a = 1'b0, we_b = 1'b0;
    logic [AW-1:0] wa_a = '0, wa_b = '0;
    logic [W-1:0]  wd_a = '0, wd_b = '0;

    logic [2*W-1:0] rd_n, rd_y;
    logic           ready_n, ready_y, coll_n, coll_y, pcwr_n, pcwr_y;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    regfile_mp #(.WIDTH(W), .NREGS(16), .NRD(2), .BYPASS(0)) dut_n (
        .clk(clk), .reset(reset), .ra({ra1, ra0}), .rd(rd_n), .pc_in(pc_in),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
        .ready(ready_n), .err_coll(coll_n), .err_pcwr(pcwr_n)
    );

    regfile_mp #(.WIDTH(W), .NREGS(16), .NRD(2), .BYPASS(1)) dut_y (
        .clk(clk), .reset(reset), .ra({ra1, ra0}), .rd(rd_y), .pc_in(pc_in),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
        .ready(ready_y), .err_coll(coll_y), .err_pcwr(pcwr_y)
    );

    // Reference model: an array of 15 registers, a count of clear cycles left,
    // and the error flags seen after each edge.
    logic [W-1:0] m_rf [15];
    int           m_clr_left = 15;
    bit           m_ready = 0;
    bit           m_coll = 0;
    bit           m_pcwr = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_clr_left = 15;
            m_ready    = 0;
            m_coll     = 0;
            m_pcwr     = 0;
        end else if (!m_ready) begin
            m_rf[15 - m_clr_left] = '0;
            m_clr_left = m_clr_left - 1;
            m_ready    = (m_clr_left == 0);
            m_coll     = 0;
            m_pcwr     = 0;
        end else begin
            m_coll = we_a && we_b && (wa_a == wa_b) && (wa_a != 15);
            m_pcwr = (we_a && wa_a == 15) || (we_b && wa_b == 15);
            if (we_a && wa_a != 15) m_rf[wa_a] = wd_a;
            if (we_b && wa_b != 15) m_rf[wa_b] = wd_b;
        end
    end

    function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (!m_ready)                      return '0;
        if (a == 15)                       return pc_in;
        if (byp && we_b && wa_b == a)      return wd_b;
        if (byp && we_a && wa_a == a)      return wd_a;
        return m_rf[a];
    endfunction

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic idle_writes();
        we_a = 1'b0;
        we_b = 1'b0;
    endtask

    // Pulse reset for one cycle; returns at the negedge with reset low.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Count cycles with ready low (bounded); reads must be zero meanwhile, PC included.
    task automatic wait_ready(input string nm);
        int lows = 0;
        pc_in = 32'hFFFF_0000;
        ra0 = 4'd15;
        #1;
        while (ready_n !== 1'b1 && lows < 40) begin
            check({nm, "_clr_rd"}, rd_n[W-1:0], '0);
            lows++;
            @(negedge clk);
            ra0 = AW'(lows % 16);
            #1;
        end
        check({nm, "_low_cycles"}, W'(lows), W'(15));
        check({nm, "_ready_byp"}, W'(ready_y), W'(1));
    endtask

    typedef struct {
        logic          we_a;
        logic [AW-1:0] wa_a;
        logic [W-1:0]  wd_a;
        logic          we_b;
        logic [AW-1:0] wa_b;
        logic [W-1:0]  wd_b;
        logic [W-1:0]  pc;
        logic [AW-1:0] chk;
        logic [W-1:0]  exp_rd;
        logic          exp_coll;
        logic          exp_pcwr;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{1'b1, 4'd3,  32'hDEAD_BEEF, 1'b0, 4'd0,  32'h0,         32'h0,   4'd3,  32'hDEAD_BEEF, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 4'd4,  32'h1111_2222, 1'b1, 4'd5,  32'h3333_4444, 32'h0,   4'd4,  32'h1111_2222, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,         32'h0,   4'd5,  32'h3333_4444, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 4'd7,  32'h1,         1'b1, 4'd7,  32'h2,         32'h0,   4'd7,  32'h2,         1'b1, 1'b0};
        tbl[4] = '{1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,         32'h0,   4'd7,  32'h2,         1'b0, 1'b0};
        tbl[5] = '{1'b1, 4'd15, 32'h5,         1'b0, 4'd0,  32'h0,         32'h100, 4'd15, 32'h100,       1'b0, 1'b1};
        tbl[6] = '{1'b1, 4'd6,  32'hA5A5,      1'b1, 4'd15, 32'h9,         32'h200, 4'd6,  32'hA5A5,      1'b0, 1'b1};
        tbl[7] = '{1'b0, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,         32'h200, 4'd14, 32'h0,         1'b0, 1'b0};
        tbl[8] = '{1'b0, 4'd0,  32'h0,         1'b1, 4'd3,  32'h1234_5678, 32'h0,   4'd3,  32'h1234_5678, 1'b0, 1'b0};

        // Power-on reset and clear.
        @(negedge clk);
        reset = 1'b0;
        wait_ready("por");
        for (int a = 0; a < 15; a++) begin
            ra0 = AW'(a);
            ra1 = AW'(14 - a);
            #1;
            check("por_rd0", rd_n[W-1:0], '0);
            check("por_rd1", rd_y[2*W-1:W], '0);
        end

        // Directed write vectors, each checked the cycle after the write.
        foreach (tbl[i]) begin
            @(negedge clk);
            we_a = tbl[i].we_a; wa_a = tbl[i].wa_a; wd_a = tbl[i].wd_a;
            we_b = tbl[i].we_b; wa_b = tbl[i].wa_b; wd_b = tbl[i].wd_b;
            pc_in = tbl[i].pc;
            ra0 = tbl[i].chk;
            @(negedge clk);
            idle_writes();
            #1;
            check($sformatf("vec%0d_rd", i), rd_n[W-1:0], tbl[i].exp_rd);
            check($sformatf("vec%0d_rd_byp", i), rd_y[W-1:0], tbl[i].exp_rd);
            check($sformatf("vec%0d_coll", i), W'(coll_n), W'(tbl[i].exp_coll));
            check($sformatf("vec%0d_pcwr", i), W'(pcwr_y), W'(tbl[i].exp_pcwr));
        end

        // Same-cycle visibility: forwarded only by the bypass instance.
        @(negedge clk);
        we_a = 1'b1; wa_a = 4'd3; wd_a = 32'hCAFE_F00D;
        ra0 = 4'd3; ra1 = 4'd3;
        #1;
        check("byp0_old", rd_n[W-1:0], 32'h1234_5678);
        check("byp1_new", rd_y[W-1:0], 32'hCAFE_F00D);
        check("byp1_port1", rd_y[2*W-1:W], 32'hCAFE_F00D);
        @(negedge clk);
        idle_writes();
        #1;
        check("byp0_next", rd_n[W-1:0], 32'hCAFE_F00D);
        @(negedge clk);
        we_a = 1'b1; wa_a = 4'd8; wd_a = 32'h1;
        we_b = 1'b1; wa_b = 4'd8; wd_b = 32'h2;
        ra0 = 4'd8;
        #1;
        check("byp_b_first", rd_y[W-1:0], 32'h2);
        check("byp_none", rd_n[W-1:0], 32'h0);
        @(negedge clk);
        idle_writes();

        // Reset in RUN with r2=9, then reset again partway through the clear.
        we_a = 1'b1; wa_a = 4'd2; wd_a = 32'h9; ra0 = 4'd2;
        @(negedge clk);
        idle_writes();
        #1;
        check("r2_set", rd_n[W-1:0], 32'h9);
        do_reset();
        repeat (6) @(negedge clk);
        check("midclr_ready", W'(ready_n), W'(0));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_ready("midclr");
        ra0 = 4'd2; ra1 = 4'd2;
        #1;
        check("r2_cleared", rd_n[W-1:0], '0);
        check("r2_cleared_byp", rd_y[2*W-1:W], '0);

        // Randomised traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 149) == 0);
            we_a  = $urandom_range(0, 1);
            we_b  = $urandom_range(0, 2) == 0;
            wa_a  = AW'($urandom_range(0, 15));
            wa_b  = ($urandom_range(0, 3) == 0) ? wa_a : AW'($urandom_range(0, 15));
            wd_a  = $urandom;
            wd_b  = $urandom;
            pc_in = $urandom;
            ra0   = ($urandom_range(0, 1) == 0) ? wa_a : AW'($urandom_range(0, 15));
            ra1   = ($urandom_range(0, 1) == 0) ? wa_b : AW'($urandom_range(0, 15));
            #1;
            check("rnd_ready", W'(ready_n), W'(m_ready));
            check("rnd_coll", W'(coll_n), W'(m_coll));
            check("rnd_pcwr", W'(pcwr_n), W'(m_pcwr));
            check("rnd_coll_byp", W'(coll_y), W'(m_coll));
            check("rnd_pcwr_byp", W'(pcwr_y), W'(m_pcwr));
            check("rnd_rd0", rd_n[W-1:0], exp_rd(ra0, 0));
            check("rnd_rd1", rd_n[2*W-1:W], exp_rd(ra1, 0));
            check("rnd_rd0_byp", rd_y[W-1:0], exp_rd(ra0, 1));
            check("rnd_rd1_byp", rd_y[2*W-1:W], exp_rd(ra1, 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
